rx_frame_arbiter: RTL and testbench
===================================

# rx_frame_arbiter

Frame-level 2:1 arbiter that shares the single downstream firewall filter datapath between two GMII receive front-ends. Whole frames from the two receivers are granted on a round-robin basis. A frame that starts while the datapath is busy is dropped and counted. Each forwarded frame is length-checked and protected by an inactivity watchdog, and a terminated frame is closed with an error flag.

## Interface
Parameters:
- MIN_LEN, 64: minimum legal frame length in bytes (inclusive).
- MAX_LEN, 1518: maximum legal frame length in bytes (inclusive).
- WDOG_CYC, 32: number of consecutive granted cycles without a valid byte before the frame is aborted.

Ports (one clock; reset asynchronous, active-low):
- clk, input, 1: system clock.
- reset, input, 1: asynchronous active-low reset.
- en, input, 1: when low, no new grants are issued.
- p0_sof / p1_sof, input, 1 each: one-cycle frame-start pulse.
- p0_data / p1_data, input, 8 each: receive byte.
- p0_valid / p1_valid, input, 1 each: data byte valid.
- p0_eof / p1_eof, input, 1 each: one-cycle frame-end pulse, issued after the last byte.
- cnt_clr, input, 1: synchronous clear of both drop counters.
- out_sof, output, 1: start of forwarded frame.
- out_data, output, 8: forwarded byte.
- out_valid, output, 1: forwarded byte valid.
- out_eof, output, 1: end of forwarded frame.
- out_err, output, 1: frame error flag; qualified only by out_eof.
- out_port, output, 1: source port of the current frame; held from out_sof through out_eof.
- drop_cnt0 / drop_cnt1, output, 16 each: saturating dropped-frame counters.

## Operation
- State: IDLE or FWD. Internal registers:
  - sel: granted port.
  - rr: last granted port; reset value 1.
  - len: 11 bits, saturates at 2047.
  - wdog: 6 bits.
  - skip0 / skip1: per-port drop-tracking flags.
- Arbitration rules:
  - A sof on a port clears that port's skip flag before arbitration.
  - In IDLE with en=1, a sof on one port grants that port: sel and rr are set to that port, and the state goes to FWD.
  - Both sof in the same cycle: grant the port != rr. The loser's skip flag is set and its drop counter increments.
- A frame is dropped and counted (skip set, counter +1) when its sof arrives in any of these cases:
  - the block is in FWD;
  - the block is in IDLE with en=0;
  - it coincides with the eof of the granted port.
- Dropped frames are never forwarded. While a port's skip flag is set, its valid and eof are ignored. The skip flag clears on that port's eof.
- FWD behaviour:
  - Each valid byte from sel is forwarded and increments len.
  - Inputs from the non-selected port are treated as above.
  - On sel's eof: out_eof is asserted, out_err = (len < MIN_LEN) or (len > MAX_LEN), and the state returns to IDLE.
- Watchdog:
  - wdog clears on grant and on every valid byte from sel; otherwise it increments by 1 per FWD cycle.
  - When wdog reaches WDOG_CYC: out_eof is asserted with out_err=1, the skip flag of sel is set (no count), and the state goes to IDLE.
- Bytes with no preceding granted sof, such as those following a mid-frame reset, are ignored.
- Drop counters saturate at 0xFFFF. cnt_clr has priority: a drop in the same cycle as cnt_clr is lost and the counter reads 0.
- Reset values:
  - All outputs 0: out_* and drop_cnt*.
  - State IDLE, rr=1, len=0, wdog=0, skip flags 0.

## Timing
- All outputs are registered.
- Latency: an input event (sof, byte, eof) on a granted port at cycle t appears on out_* at t+1.
- out_sof is a one-cycle pulse at t+1. out_port is valid from that cycle.
- out_eof and out_err are a one-cycle pulse at t+1 after the input eof, or the cycle after the watchdog expiry.
- A sof at t+1 after the granted eof at t can be granted; this gives back-to-back frames with zero idle cycles.
- out_valid is 0 in every cycle where no granted byte was received at t-1.
- Watchdog abort occurs exactly WDOG_CYC cycles after the last granted byte (or after the grant). out_eof follows one cycle after that.
- Reset is asynchronous: outputs drop to 0 immediately. Operation resumes on the first clk edge after release.

## Test plan
- Basic forwarding: p0 sof, 64 bytes 0x00..0x3F, eof -> out_sof, then 64 out_valid bytes identical and 1 cycle delayed, then out_eof with out_err=0 and out_port=0.
- Simultaneous start after reset: p0_sof and p1_sof in the same cycle -> port 0 granted, drop_cnt1=1. Repeat after the frames end -> port 1 granted, drop_cnt0=1.
- Length checks:
  - 63-byte frame -> out_err=1.
  - 1518 bytes -> out_err=0.
  - 1519 bytes -> out_err=1.
  - 2100 bytes -> out_err=1 with no length wrap.
- Watchdog abort: p1 sof, 10 bytes, then valid held low for 32 cycles -> out_eof with out_err=1. Later p1 bytes and its eof produce no output; the next p1 sof is granted normally.
- Busy and disabled drops:
  - p1 sof during a p0 frame -> p1 dropped, drop_cnt1 +1.
  - en=0 then p0 sof -> drop_cnt0 +1.
  - cnt_clr coincident with a drop -> counter 0.
  - Saturation: preload via 65536 drops -> counter stays 0xFFFF.
- Reset mid-frame: reset asserted at p0 byte 20 -> all outputs 0 at once. The remaining p0 bytes after release produce no out_valid; the next sof is granted normally.

Source files
------------

// File: rtl/rx_frame_arbiter.sv
// Frame-level 2:1 round-robin arbiter feeding one downstream filter datapath from two GMII receivers.
// Frames that start while the datapath is busy or disabled are dropped, skipped until their eof, and counted.
module rx_frame_arbiter #(
  parameter int MIN_LEN  = 64,
  parameter int MAX_LEN  = 1518,
  parameter int WDOG_CYC = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        p0_sof,
  input  logic        p1_sof,
  input  logic [7:0]  p0_data,
  input  logic [7:0]  p1_data,
  input  logic        p0_valid,
  input  logic        p1_valid,
  input  logic        p0_eof,
  input  logic        p1_eof,
  input  logic        cnt_clr,
  output logic        out_sof,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_eof,
  output logic        out_err,
  output logic        out_port,
  output logic [15:0] drop_cnt0,
  output logic [15:0] drop_cnt1
);

  typedef enum logic {IDLE, FWD} state_t;

  localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L    = 11'(MAX_LEN);
  localparam logic [10:0] LEN_SAT  = 11'h7FF;
  localparam logic [5:0]  WDOG_LIM = 6'(WDOG_CYC - 1);

  state_t      state;
  logic        sel;
  logic        rr;
  logic [10:0] len;
  logic [5:0]  wdog;
  logic        skip0;
  logic        skip1;

  logic        sel_valid;
  logic        sel_eof;
  logic [7:0]  sel_data;
  logic        sel_byte;
  logic        idle_grant;
  logic        grant_port;
  logic        grant_valid;
  logic [7:0]  grant_data;
  logic        drop0;
  logic        drop1;
  logic [10:0] len_inc;
  logic [10:0] len_cur;

  // A sof loses whenever it is not the one granted from IDLE: busy, disabled, or the rr loser.
  always_comb begin
    sel_valid   = sel ? (p1_valid & ~skip1) : (p0_valid & ~skip0);
    sel_eof     = sel ? (p1_eof & ~skip1) : (p0_eof & ~skip0);
    sel_data    = sel ? p1_data : p0_data;
    sel_byte    = (state == FWD) && sel_valid;
    idle_grant  = (state == IDLE) && en && (p0_sof || p1_sof);
    grant_port  = (p0_sof && p1_sof) ? ~rr : p1_sof;
    grant_valid = grant_port ? p1_valid : p0_valid;
    grant_data  = grant_port ? p1_data : p0_data;
    drop0       = p0_sof && !(idle_grant && !grant_port);
    drop1       = p1_sof && !(idle_grant && grant_port);
    len_inc     = (len == LEN_SAT) ? len : len + 11'd1;
    len_cur     = sel_byte ? len_inc : len;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sel       <= 1'b0;
      rr        <= 1'b1;
      len       <= 11'd0;
      wdog      <= 6'd0;
      skip0     <= 1'b0;
      skip1     <= 1'b0;
      out_sof   <= 1'b0;
      out_data  <= 8'd0;
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
      out_err   <= 1'b0;
      out_port  <= 1'b0;
      drop_cnt0 <= 16'd0;
      drop_cnt1 <= 16'd0;
    end else begin
      out_sof   <= 1'b0;
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
      out_err   <= 1'b0;

      if (drop0)                 skip0 <= 1'b1;
      else if (p0_sof || p0_eof) skip0 <= 1'b0;
      if (drop1)                 skip1 <= 1'b1;
      else if (p1_sof || p1_eof) skip1 <= 1'b0;

      case (state)
        IDLE: begin
          if (idle_grant) begin
            state     <= FWD;
            sel       <= grant_port;
            rr        <= grant_port;
            out_port  <= grant_port;
            out_sof   <= 1'b1;
            wdog      <= 6'd0;
            len       <= grant_valid ? 11'd1 : 11'd0;
            out_valid <= grant_valid;
            if (grant_valid) out_data <= grant_data;
          end
        end
        FWD: begin
          if (sel_byte) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            len       <= len_inc;
            wdog      <= 6'd0;
          end else begin
            wdog <= wdog + 6'd1;
          end
          // A real eof wins over a watchdog expiry landing on the same cycle.
          if (sel_eof) begin
            out_eof <= 1'b1;
            out_err <= (len_cur < MIN_L) || (len_cur > MAX_L);
            state   <= IDLE;
          end else if (!sel_byte && wdog == WDOG_LIM) begin
            out_eof <= 1'b1;
            out_err <= 1'b1;
            state   <= IDLE;
            if (sel) skip1 <= 1'b1;
            else     skip0 <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (cnt_clr)                            drop_cnt0 <= 16'd0;
      else if (drop0 && drop_cnt0 != 16'hFFFF) drop_cnt0 <= drop_cnt0 + 16'd1;
      if (cnt_clr)                            drop_cnt1 <= 16'd0;
      else if (drop1 && drop_cnt1 != 16'hFFFF) drop_cnt1 <= drop_cnt1 + 16'd1;
    end
  end

endmodule

// File: tb/tb_rx_frame_arbiter.sv
// Directed bench for rx_frame_arbiter: a vector table for arbitration and drop counting,
// plus hand-written sequences for length limits, watchdog abort, counter saturation and mid-frame reset.
module tb_rx_frame_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        p0_sof, p1_sof;
  logic [7:0]  p0_data, p1_data;
  logic        p0_valid, p1_valid;
  logic        p0_eof, p1_eof;
  logic        cnt_clr;
  logic        out_sof;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_eof;
  logic        out_err;
  logic        out_port;
  logic [15:0] drop_cnt0, drop_cnt1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int en, clr, s0, s1, v0, v1, e0, e1, d0, d1;
    int xs, xv, xe, xerr, xp, xd, c0, c1;
  } vec_t;

  vec_t vecs[16];

  rx_frame_arbiter #(.MIN_LEN(64), .MAX_LEN(1518), .WDOG_CYC(32)) dut (
    .clk(clk), .reset(reset), .en(en),
    .p0_sof(p0_sof), .p1_sof(p1_sof),
    .p0_data(p0_data), .p1_data(p1_data),
    .p0_valid(p0_valid), .p1_valid(p1_valid),
    .p0_eof(p0_eof), .p1_eof(p1_eof),
    .cnt_clr(cnt_clr),
    .out_sof(out_sof), .out_data(out_data), .out_valid(out_valid),
    .out_eof(out_eof), .out_err(out_err), .out_port(out_port),
    .drop_cnt0(drop_cnt0), .drop_cnt1(drop_cnt1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    p0_sof = 1'b0; p1_sof = 1'b0;
    p0_valid = 1'b0; p1_valid = 1'b0;
    p0_eof = 1'b0; p1_eof = 1'b0;
    p0_data = 8'd0; p1_data = 8'd0;
    cnt_clr = 1'b0;
  endtask

  task automatic setPort(input int port, input logic sof, input logic valid,
                         input logic [7:0] data, input logic eof);
    if (port == 0) begin
      p0_sof = sof; p0_valid = valid; p0_data = data; p0_eof = eof;
    end else begin
      p1_sof = sof; p1_valid = valid; p1_data = data; p1_eof = eof;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    en       = (v.en != 0);
    cnt_clr  = (v.clr != 0);
    p0_sof   = (v.s0 != 0);
    p1_sof   = (v.s1 != 0);
    p0_valid = (v.v0 != 0);
    p1_valid = (v.v1 != 0);
    p0_eof   = (v.e0 != 0);
    p1_eof   = (v.e1 != 0);
    p0_data  = 8'(v.d0);
    p1_data  = 8'(v.d1);
  endtask

  // Whole frame: sof, n bytes counting up from 0, eof; bytes are tallied and compared once per frame.
  task automatic sendFrame(input int port, input int n, input int exp_err, input string tag);
    int bad = 0;
    setPort(port, 1'b1, 1'b0, 8'd0, 1'b0);
    tick();
    checkOutput({tag, " sof"}, 32'(out_sof), 1);
    checkOutput({tag, " port"}, 32'(out_port), port);
    for (int i = 0; i < n; i++) begin
      setPort(port, 1'b0, 1'b1, 8'(i), 1'b0);
      tick();
      if (!(out_valid === 1'b1 && out_data === 8'(i) && out_port === 1'(port))) bad++;
    end
    checkOutput({tag, " bad bytes"}, bad, 0);
    setPort(port, 1'b0, 1'b0, 8'd0, 1'b1);
    tick();
    checkOutput({tag, " eof"}, 32'(out_eof), 1);
    checkOutput({tag, " err"}, 32'(out_err), exp_err);
    checkOutput({tag, " eof port"}, 32'(out_port), port);
    checkOutput({tag, " eof valid"}, 32'(out_valid), 0);
    setPort(port, 1'b0, 1'b0, 8'd0, 1'b0);
    tick();
    checkOutput({tag, " eof pulse"}, 32'(out_eof), 0);
  endtask

  initial begin
    int bad;

    //           en clr s0 s1 v0 v1 e0 e1 d0    d1    xs xv xe xerr xp xd    c0 c1
    vecs[0]  = '{1, 0,  1, 1, 0, 0, 0, 0, 0,    0,    1, 0, 0, 0,   0, 0,    0, 1};
    vecs[1]  = '{1, 0,  0, 0, 1, 0, 0, 0, 'hAA, 0,    0, 1, 0, 0,   0, 'hAA, 0, 1};
    vecs[2]  = '{1, 0,  0, 0, 0, 1, 0, 0, 0,    'h55, 0, 0, 0, 0,   0, 0,    0, 1};
    vecs[3]  = '{1, 0,  0, 0, 0, 0, 1, 1, 0,    0,    0, 0, 1, 1,   0, 0,    0, 1};
    vecs[4]  = '{1, 0,  1, 1, 0, 0, 0, 0, 0,    0,    1, 0, 0, 0,   1, 0,    1, 1};
    vecs[5]  = '{1, 0,  0, 0, 0, 1, 0, 0, 0,    'h11, 0, 1, 0, 0,   1, 'h11, 1, 1};
    vecs[6]  = '{1, 0,  1, 0, 0, 1, 0, 0, 0,    'h22, 0, 1, 0, 0,   1, 'h22, 2, 1};
    vecs[7]  = '{1, 0,  1, 0, 0, 0, 0, 1, 0,    0,    0, 0, 1, 1,   1, 0,    3, 1};
    vecs[8]  = '{1, 0,  1, 0, 0, 0, 0, 0, 0,    0,    1, 0, 0, 0,   0, 0,    3, 1};
    vecs[9]  = '{1, 0,  0, 0, 0, 0, 1, 0, 0,    0,    0, 0, 1, 1,   0, 0,    3, 1};
    vecs[10] = '{0, 0,  1, 0, 0, 0, 0, 0, 0,    0,    0, 0, 0, 0,   0, 0,    4, 1};
    vecs[11] = '{0, 1,  0, 1, 0, 0, 0, 0, 0,    0,    0, 0, 0, 0,   0, 0,    0, 0};
    vecs[12] = '{1, 0,  0, 1, 0, 0, 0, 0, 0,    0,    1, 0, 0, 0,   1, 0,    0, 0};
    vecs[13] = '{1, 0,  0, 0, 0, 0, 0, 1, 0,    0,    0, 0, 1, 1,   1, 0,    0, 0};
    vecs[14] = '{1, 0,  1, 0, 0, 0, 0, 0, 0,    0,    1, 0, 0, 0,   0, 0,    0, 0};
    vecs[15] = '{1, 0,  0, 0, 0, 0, 1, 0, 0,    0,    0, 0, 1, 1,   0, 0,    0, 0};

    clearInputs();
    en = 1'b1;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    checkOutput("reset outputs", 32'({out_sof, out_valid, out_eof, out_err, out_port, out_data}), 0);
    checkOutput("reset drop_cnt0", 32'(drop_cnt0), 0);
    checkOutput("reset drop_cnt1", 32'(drop_cnt1), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d out_sof", i), 32'(out_sof), vecs[i].xs);
      checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid), vecs[i].xv);
      checkOutput($sformatf("vec%0d out_eof", i), 32'(out_eof), vecs[i].xe);
      checkOutput($sformatf("vec%0d drop_cnt0", i), 32'(drop_cnt0), vecs[i].c0);
      checkOutput($sformatf("vec%0d drop_cnt1", i), 32'(drop_cnt1), vecs[i].c1);
      if (vecs[i].xv != 0)
        checkOutput($sformatf("vec%0d out_data", i), 32'(out_data), vecs[i].xd);
      if (vecs[i].xe != 0)
        checkOutput($sformatf("vec%0d out_err", i), 32'(out_err), vecs[i].xerr);
      if (vecs[i].xs != 0 || vecs[i].xv != 0 || vecs[i].xe != 0)
        checkOutput($sformatf("vec%0d out_port", i), 32'(out_port), vecs[i].xp);
    end
    clearInputs();
    en = 1'b1;
    tick();

    sendFrame(0, 64, 0, "len64");
    sendFrame(0, 63, 1, "len63");
    sendFrame(0, 1518, 0, "len1518");
    sendFrame(0, 1519, 1, "len1519");
    sendFrame(1, 2100, 1, "len2100");

    // Watchdog: 10 bytes then 32 silent cycles, abort lands on the 32nd.
    setPort(1, 1'b1, 1'b0, 8'd0, 1'b0);
    tick();
    checkOutput("wdog sof", 32'(out_sof), 1);
    for (int i = 0; i < 10; i++) begin
      setPort(1, 1'b0, 1'b1, 8'(i), 1'b0);
      tick();
    end
    setPort(1, 1'b0, 1'b0, 8'd0, 1'b0);
    bad = 0;
    for (int k = 1; k < 32; k++) begin
      tick();
      if (out_eof !== 1'b0) bad++;
    end
    checkOutput("wdog early eof", bad, 0);
    tick();
    checkOutput("wdog eof", 32'(out_eof), 1);
    checkOutput("wdog err", 32'(out_err), 1);
    checkOutput("wdog port", 32'(out_port), 1);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      setPort(1, 1'b0, i < 5, 8'(i), i == 5);
      tick();
      if (out_valid !== 1'b0 || out_eof !== 1'b0) bad++;
    end
    setPort(1, 1'b0, 1'b0, 8'd0, 1'b0);
    tick();
    checkOutput("wdog tail ignored", bad, 0);
    sendFrame(1, 64, 0, "after wdog");

    // Saturation: sof held with en=0 drops one frame per cycle.
    en = 1'b0;
    p1_sof = 1'b1;
    repeat (65535) tick();
    checkOutput("sat reach", 32'(drop_cnt1), 65535);
    repeat (3) tick();
    checkOutput("sat hold", 32'(drop_cnt1), 65535);
    p1_sof = 1'b0;
    en = 1'b1;
    tick();

    // Mid-frame reset at byte 20: outputs clear immediately, frame tail is ignored.
    setPort(0, 1'b1, 1'b0, 8'd0, 1'b0);
    tick();
    for (int i = 0; i < 20; i++) begin
      setPort(0, 1'b0, 1'b1, 8'(i), 1'b0);
      tick();
    end
    setPort(0, 1'b0, 1'b1, 8'd20, 1'b0);
    #2 reset = 1'b0;
    #1;
    checkOutput("midreset outputs", 32'({out_sof, out_valid, out_eof, out_err, out_port, out_data}), 0);
    checkOutput("midreset drop_cnt1", 32'(drop_cnt1), 0);
    tick();
    reset = 1'b1;
    bad = 0;
    for (int i = 21; i < 41; i++) begin
      setPort(0, 1'b0, 1'b1, 8'(i), 1'b0);
      tick();
      if (out_valid !== 1'b0 || out_sof !== 1'b0 || out_eof !== 1'b0) bad++;
    end
    setPort(0, 1'b0, 1'b0, 8'd0, 1'b1);
    tick();
    if (out_eof !== 1'b0) bad++;
    setPort(0, 1'b0, 1'b0, 8'd0, 1'b0);
    tick();
    checkOutput("midreset tail ignored", bad, 0);
    sendFrame(0, 64, 0, "post reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
